// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the floating-point adder sequencer.
// Op/state encodings and the operand-select helper live here.
package fp_seq_pkg;

    typedef enum logic [1:0] {
        OP_FAD   = 2'd0,
        OP_FSB   = 2'd1,
        OP_FLT   = 2'd2,
        OP_FLOOR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [31:0] FP_2P23     = 32'h4B00_0000;
    localparam int          TIMEOUT_DEF = 8;

    // FSB flips the sign of b; FLT/FLOOR add 2^23 to shift the integer point.
    function automatic logic [31:0] y_operand(
        input op_e         op,
        input logic [31:0] b
    );
        logic [31:0] y;
        y = FP_2P23;
        unique case (1'b1)
            (op == OP_FAD): y = b;
            (op == OP_FSB): y = {~b[31], b[30:0]};
            default:        y = FP_2P23;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/fp_add_sequencer.sv
// Issue/writeback sequencer for the pipelined FP adder.
// Forms operands, holds run until stall drops, returns result.
module fp_add_sequencer
    import fp_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        add_ce,
    output logic        add_run,
    output logic        add_u,
    output logic        add_v,
    output logic [31:0] add_x,
    output logic [31:0] add_y,
    input  logic        add_stall,
    input  logic [31:0] add_z,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_z,
    output logic        rsp_n,
    output logic        rsp_zf,
    output logic        rsp_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state;
    logic [CW-1:0] cnt;
    op_e           op;

    assign op     = op_e'(req_op);
    assign add_ce = 1'b1;
    assign rsp_n  = rsp_z[31];
    assign rsp_zf = (rsp_z == 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            add_run   <= 1'b0;
            add_u     <= 1'b0;
            add_v     <= 1'b0;
            add_x     <= 32'd0;
            add_y     <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_z     <= 32'd0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        add_x     <= req_a;
                        add_y     <= y_operand(op, req_b);
                        add_u     <= (op == OP_FLT);
                        add_v     <= (op == OP_FLOOR);
                        cnt       <= '0;
                        add_run   <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!add_stall) begin
                        rsp_z     <= add_z;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        add_run   <= 1'b0;
                        state     <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_z     <= 32'd0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        add_run   <= 1'b0;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    // No same-cycle re-accept: ready rises only in IDLE.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    add_run   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a behavioural adder/stall model.
// Adder stalls for 3 RUN cycles, or indefinitely when stall_hold is set.
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        add_ce;
    logic        add_run;
    logic        add_u;
    logic        add_v;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_stall;
    logic [31:0] add_z;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_z;
    logic        rsp_n;
    logic        rsp_zf;
    logic        rsp_err;

    int checks = 0;
    int fails  = 0;

    logic        stall_hold = 1'b0;
    logic [31:0] z_val = 32'd0;
    int unsigned acnt = 0;

    always #5 clk = ~clk;

    fp_add_sequencer #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .add_ce(add_ce), .add_run(add_run),
        .add_u(add_u), .add_v(add_v),
        .add_x(add_x), .add_y(add_y),
        .add_stall(add_stall), .add_z(add_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_n(rsp_n),
        .rsp_zf(rsp_zf), .rsp_err(rsp_err)
    );

    // Adder model: result valid on the 4th run cycle, garbage before.
    always @(posedge clk) begin
        if (!add_run) acnt <= 0;
        else          acnt <= acnt + 1;
    end
    assign add_stall = add_run && (stall_hold || acnt < 3);
    assign add_z     = add_stall ? 32'hDEAD_BEEF : z_val;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns in the negedge of RUN cycle 1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] z);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        z_val     = z;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts cycles from RUN cycle 1 until rsp_valid, bounded.
    task automatic wait_rsp(output int cyc, output int runs);
        cyc  = 1;
        runs = 0;
        while (1) begin
            if (add_run) runs++;
            if (rsp_valid || cyc >= 40) break;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic vec(
        input string t, input logic [1:0] op,
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
        input logic [31:0] ey, input logic eu, input logic ev,
        input logic [31:0] ez, input logic en, input logic ezf,
        input logic eerr, input int elat, input int eruns
    );
        int cyc, runs;
        issue(op, a, b, z);
        chk({t, ".x"}, add_x, a);
        chk({t, ".y"}, add_y, ey);
        chk({t, ".u"}, 32'(add_u), 32'(eu));
        chk({t, ".v"}, 32'(add_v), 32'(ev));
        chk({t, ".busy"}, 32'(req_ready), 32'd0);
        wait_rsp(cyc, runs);
        chk({t, ".lat"}, cyc, elat);
        chk({t, ".runs"}, runs, eruns);
        chk({t, ".z"}, rsp_z, ez);
        chk({t, ".n"}, 32'(rsp_n), 32'(en));
        chk({t, ".zf"}, 32'(rsp_zf), 32'(ezf));
        chk({t, ".err"}, 32'(rsp_err), 32'(eerr));
        if (rsp_ready) begin
            @(negedge clk);
            chk({t, ".done_v"}, 32'(rsp_valid), 32'd0);
            chk({t, ".done_r"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, runs, seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.ce", 32'(add_ce), 32'd1);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.run", 32'(add_run), 32'd0);
        chk("rst.uv", {30'd0, add_u, add_v}, 32'd0);
        chk("rst.x", add_x, 32'd0);
        chk("rst.y", add_y, 32'd0);
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.z", rsp_z, 32'd0);
        chk("rst.err", 32'(rsp_err), 32'd0);
        chk("rst.n", 32'(rsp_n), 32'd0);
        chk("rst.zf", 32'(rsp_zf), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        vec("fad", 2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
            32'h4000_0000, 1'b0, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 5, 4);
        vec("fsb", 2'd1, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,
            32'hBF80_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 5, 4);
        vec("flt", 2'd2, 32'h0000_0005, 32'h1234_5678, 32'h40A0_0000,
            32'h4B00_0000, 1'b1, 1'b0, 32'h40A0_0000, 1'b0, 1'b0, 1'b0, 5, 4);
        vec("flr+", 2'd3, 32'h4060_0000, 32'h0, 32'h0000_0003,
            32'h4B00_0000, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 5, 4);
        vec("flr-", 2'd3, 32'hC060_0000, 32'h0, 32'hFFFF_FFFC,
            32'h4B00_0000, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 5, 4);

        stall_hold = 1'b1;
        vec("tmo", 2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
            32'h4000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 9, 8);
        stall_hold = 1'b0;
        vec("post", 2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
            32'h4000_0000, 1'b0, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 5, 4);

        // Backpressure: new request offered while the response is held.
        rsp_ready = 1'b0;
        vec("bp", 2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
            32'h4000_0000, 1'b0, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 5, 4);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_a     = 32'h0000_0005;
        req_b     = 32'h0;
        z_val     = 32'h40A0_0000;
        repeat (2) begin
            @(negedge clk);
            chk("bp.valid", 32'(rsp_valid), 32'd1);
            chk("bp.hold", rsp_z, 32'h4040_0000);
            chk("bp.ready", 32'(req_ready), 32'd0);
            chk("bp.run", 32'(add_run), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp.idle_v", 32'(rsp_valid), 32'd0);
        chk("bp.idle_r", 32'(req_ready), 32'd1);
        chk("bp.idle_run", 32'(add_run), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp2.run", 32'(add_run), 32'd1);
        chk("bp2.u", 32'(add_u), 32'd1);
        wait_rsp(cyc, runs);
        chk("bp2.lat", cyc, 5);
        chk("bp2.z", rsp_z, 32'h40A0_0000);
        @(negedge clk);

        // Reset during RUN cycle 2 drops the operation.
        issue(2'd2, 32'h0000_0005, 32'h0, 32'h40A0_0000);
        @(negedge clk);
        chk("mid.run2", 32'(add_run), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid.run", 32'(add_run), 32'd0);
        chk("mid.valid", 32'(rsp_valid), 32'd0);
        chk("mid.ready", 32'(req_ready), 32'd1);
        chk("mid.u", 32'(add_u), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || add_run) seen++;
        end
        chk("mid.quiet", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
